// File: rtl/ir_ctrl_pkg.sv
// Shared types and helpers for the IR key controller: FSM states, the queued
// event record, NEC frame byte offsets and a saturating counter step.
package ir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        GUARD = 2'd2
    } ir_ctrl_state_t;

    typedef struct packed {
        logic       is_repeat;
        logic [7:0] code;
    } ir_evt_t;

    localparam int unsigned NEC_ADDR_LSB  = 0;
    localparam int unsigned NEC_NADDR_LSB = 8;
    localparam int unsigned NEC_CMD_LSB   = 16;
    localparam int unsigned NEC_NCMD_LSB  = 24;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Small synchronous event FIFO built as a shift register so the head, valid
// and full flags all come straight from flops (no fall-through).
module ir_evt_fifo
    import ir_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic    clk25,
    input  logic    rst,
    input  logic    push_i,
    input  ir_evt_t data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output ir_evt_t head_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    ir_evt_t         ent_q [DEPTH];
    ir_evt_t         ent_d [DEPTH];
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   wr_idx;
    logic            do_pop;
    logic            do_push;
    logic            full_q;
    logic            empty_q;

    // A pop frees the tail slot in the same cycle, so push-while-full is legal then.
    always_comb begin
        ent_d   = ent_q;
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
        wr_idx  = cnt_q - CW'(do_pop);
        if (do_pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            ent_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (do_push && (CW'(i) == wr_idx)) begin
                ent_d[i] = data_i;
            end
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = ent_q[0];

endmodule

// File: rtl/ir_key_ctrl.sv
// Sits between ir_decoder and the UI: validates NEC frames, queues key events
// with auto-repeat tagging, guards the decoder after each frame, tracks key hold.
module ir_key_ctrl
    import ir_ctrl_pkg::*;
#(
    parameter logic [7:0]  ADDR       = 8'h00,
    parameter bit          ADDR_CHECK = 1'b1,
    parameter int unsigned GUARD_CYC  = 25_000,
    parameter int unsigned HOLD_CYC   = 3_000_000,
    parameter int unsigned FIFO_DEPTH = 4
)(
    input  logic        clk25,
    input  logic        rst,
    output logic        dec_enable,
    input  logic        dec_ready,
    input  logic [31:0] dec_command,
    output logic        evt_valid,
    output logic [7:0]  evt_code,
    output logic        evt_repeat,
    input  logic        evt_ready,
    output logic        key_held,
    output logic [7:0]  held_code,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned GW = $clog2(GUARD_CYC + 1);
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    ir_ctrl_state_t state_q, state_d;
    logic [31:0]    frame_q, frame_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [7:0]     held_code_q, held_code_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    logic           key_held_q, dec_enable_q;

    logic [7:0]     f_addr, f_naddr, f_cmd, f_ncmd;
    logic           integ_ok, addr_ok;
    logic           push_evt, fifo_pop, fifo_full, fifo_empty;
    ir_evt_t        evt_in, fifo_head;

    assign f_addr   = frame_q[NEC_ADDR_LSB  +: 8];
    assign f_naddr  = frame_q[NEC_NADDR_LSB +: 8];
    assign f_cmd    = frame_q[NEC_CMD_LSB   +: 8];
    assign f_ncmd   = frame_q[NEC_NCMD_LSB  +: 8];
    assign integ_ok = ((f_cmd ^ f_ncmd) == 8'hFF) && ((f_addr ^ f_naddr) == 8'hFF);
    assign addr_ok  = !ADDR_CHECK || (f_addr == ADDR);
    assign fifo_pop = !fifo_empty && evt_ready;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dec_ready) state_d = CHECK;
            CHECK:   state_d = GUARD;
            GUARD:   if (guard_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame evaluation happens only in CHECK; timers and counters follow from it.
    always_comb begin
        frame_d     = frame_q;
        guard_d     = guard_q;
        hold_d      = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        held_code_d = held_code_q;
        err_cnt_d   = err_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        push_evt    = 1'b0;
        evt_in      = '0;
        if ((state_q == IDLE) && dec_ready) begin
            frame_d = dec_command;
        end
        if (state_q == CHECK) begin
            guard_d = GW'(GUARD_CYC - 1);
            if (!integ_ok) begin
                err_cnt_d = sat_inc8(err_cnt_q);
            end else if (addr_ok) begin
                push_evt         = 1'b1;
                evt_in.is_repeat = key_held_q && (f_cmd == held_code_q);
                evt_in.code      = f_cmd;
                held_code_d      = f_cmd;
                hold_d           = HW'(HOLD_CYC);
            end
        end else if ((state_q == GUARD) && (guard_q != '0)) begin
            guard_d = guard_q - GW'(1);
        end
        if (push_evt && fifo_full && !fifo_pop) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            guard_q      <= '0;
            hold_q       <= '0;
            held_code_q  <= '0;
            err_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            key_held_q   <= 1'b0;
            dec_enable_q <= 1'b1;
        end else begin
            guard_q      <= guard_d;
            hold_q       <= hold_d;
            held_code_q  <= held_code_d;
            err_cnt_q    <= err_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            key_held_q   <= (hold_d != '0);
            dec_enable_q <= (state_d == IDLE);
        end
    end

    always_ff @(posedge clk25) begin
        frame_q <= frame_d;
    end

    ir_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk25   (clk25),
        .rst     (rst),
        .push_i  (push_evt),
        .data_i  (evt_in),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign dec_enable = dec_enable_q;
    assign evt_valid  = !fifo_empty;
    assign evt_code   = fifo_head.code;
    assign evt_repeat = fifo_head.is_repeat;
    assign key_held   = key_held_q;
    assign held_code  = held_code_q;
    assign err_cnt    = err_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl with short guard/hold windows; expected
// values are hand-derived from the NEC frame layout and cycle timing.
module tb_ir_key_ctrl;

    logic        clk25 = 1'b0;
    logic        rst;
    logic        dec_enable;
    logic        dec_ready;
    logic [31:0] dec_command;
    logic        evt_valid;
    logic [7:0]  evt_code;
    logic        evt_repeat;
    logic        evt_ready;
    logic        key_held;
    logic [7:0]  held_code;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    ir_key_ctrl #(
        .ADDR       (8'h00),
        .ADDR_CHECK (1'b1),
        .GUARD_CYC  (8),
        .HOLD_CYC   (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk25       (clk25),
        .rst         (rst),
        .dec_enable  (dec_enable),
        .dec_ready   (dec_ready),
        .dec_command (dec_command),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_repeat  (evt_repeat),
        .evt_ready   (evt_ready),
        .key_held    (key_held),
        .held_code   (held_code),
        .err_cnt     (err_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    // Called at a negedge; returns at the next negedge (cycle N+1).
    task automatic send(input logic [31:0] f);
        dec_command = f;
        dec_ready   = 1'b1;
        @(negedge clk25);
        dec_ready   = 1'b0;
    endtask

    task automatic wait_en(output int low);
        low = 0;
        while (!dec_enable && low < 100) begin
            low++;
            @(negedge clk25);
        end
    endtask

    task automatic send_wait(input string tag, input logic [31:0] f);
        int low;
        send(f);
        wait_en(low);
        check({tag, "_guard"}, 32'(low), 9);
    endtask

    task automatic pop_chk(input string tag, input logic rpt, input logic [7:0] code);
        check({tag, "_vld"}, 32'(evt_valid), 1);
        check({tag, "_rpt"}, 32'(evt_repeat), 32'(rpt));
        check({tag, "_code"}, 32'(evt_code), 32'(code));
        evt_ready = 1'b1;
        @(negedge clk25);
        evt_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int hcnt;
        rst         = 1'b1;
        dec_ready   = 1'b0;
        dec_command = '0;
        evt_ready   = 1'b0;
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        @(negedge clk25);
        check("rst_en",    32'(dec_enable), 1);
        check("rst_vld",   32'(evt_valid), 0);
        check("rst_code",  32'(evt_code), 0);
        check("rst_rpt",   32'(evt_repeat), 0);
        check("rst_held",  32'(key_held), 0);
        check("rst_hcode", 32'(held_code), 0);
        check("rst_err",   32'(err_cnt), 0);
        check("rst_drop",  32'(drop_cnt), 0);

        // Single valid frame: latency, guard length, hold state
        send(32'hE31C_FF00);
        check("t1_en_n1",  32'(dec_enable), 0);
        check("t1_vld_n1", 32'(evt_valid), 0);
        @(negedge clk25);
        check("t1_vld_n2",   32'(evt_valid), 1);
        check("t1_code",     32'(evt_code), 'h1C);
        check("t1_rpt",      32'(evt_repeat), 0);
        check("t1_held",     32'(key_held), 1);
        check("t1_hcode",    32'(held_code), 'h1C);
        wait_en(low);
        check("t1_guard", 32'(low + 1), 9);
        evt_ready = 1'b1;
        @(negedge clk25);
        evt_ready = 1'b0;
        check("t1_popped", 32'(evt_valid), 0);

        // Corrupt frame and address mismatch
        send_wait("t2a", 32'hE31D_FF00);
        check("t2a_vld",   32'(evt_valid), 0);
        check("t2a_err",   32'(err_cnt), 1);
        check("t2a_held",  32'(key_held), 1);
        check("t2a_hcode", 32'(held_code), 'h1C);
        send_wait("t2b", 32'hE31C_FE01);
        check("t2b_vld",   32'(evt_valid), 0);
        check("t2b_err",   32'(err_cnt), 1);

        // Auto-repeat inside the hold window, then hold expiry
        repeat (150) @(negedge clk25);
        check("t3_idle_held", 32'(key_held), 0);
        send_wait("t3a", 32'hE31C_FF00);
        pop_chk("t3a", 1'b0, 8'h1C);
        repeat (28) @(negedge clk25);
        send(32'hE31C_FF00);
        @(negedge clk25);
        check("t3b_rpt",  32'(evt_repeat), 1);
        check("t3b_code", 32'(evt_code), 'h1C);
        evt_ready = 1'b1;
        hcnt = 0;
        while (key_held && hcnt < 300) begin
            hcnt++;
            @(negedge clk25);
            evt_ready = 1'b0;
        end
        check("t3_hold_len", 32'(hcnt), 100);
        check("t3b_popped",  32'(evt_valid), 0);
        send_wait("t3c", 32'hE31C_FF00);
        pop_chk("t3c", 1'b0, 8'h1C);
        repeat (140) @(negedge clk25);
        send_wait("t3d", 32'hE31C_FF00);
        pop_chk("t3d", 1'b0, 8'h1C);

        // Overflow: six frames, four queued, two dropped
        for (int i = 1; i <= 6; i++) begin
            send_wait("t4", nec(8'h00, 8'(i)));
        end
        check("t4_drop", 32'(drop_cnt), 2);
        evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t4_vld",  32'(evt_valid), 1);
            check("t4_code", 32'(evt_code), 32'(i));
            @(negedge clk25);
        end
        check("t4_empty", 32'(evt_valid), 0);
        evt_ready = 1'b0;

        // dec_ready during GUARD is ignored
        send(nec(8'h00, 8'h2A));
        @(negedge clk25);
        check("t5_code", 32'(evt_code), 'h2A);
        evt_ready = 1'b1;
        @(negedge clk25);
        evt_ready   = 1'b0;
        dec_command = nec(8'h00, 8'h33);
        dec_ready   = 1'b1;
        @(negedge clk25);
        dec_ready = 1'b0;
        wait_en(low);
        check("t5_guard", 32'(low), 6);
        repeat (3) @(negedge clk25);
        check("t5_vld",   32'(evt_valid), 0);
        check("t5_hcode", 32'(held_code), 'h2A);

        // Asynchronous reset mid-GUARD with two events queued
        send_wait("t6a", nec(8'h00, 8'h41));
        send_wait("t6b", nec(8'h00, 8'h42));
        send(32'hE31D_FF00);
        @(negedge clk25);
        check("t6_pre_en",  32'(dec_enable), 0);
        check("t6_pre_err", 32'(err_cnt), 2);
        @(negedge clk25);
        #2 rst = 1'b1;
        #2;
        check("t6_en",    32'(dec_enable), 1);
        check("t6_vld",   32'(evt_valid), 0);
        check("t6_code",  32'(evt_code), 0);
        check("t6_held",  32'(key_held), 0);
        check("t6_hcode", 32'(held_code), 0);
        check("t6_err",   32'(err_cnt), 0);
        check("t6_drop",  32'(drop_cnt), 0);
        @(negedge clk25);
        rst = 1'b0;
        @(negedge clk25);
        check("t6_rel_en",  32'(dec_enable), 1);
        check("t6_rel_vld", 32'(evt_valid), 0);
        send_wait("t6c", nec(8'h00, 8'h55));
        pop_chk("t6c", 1'b0, 8'h55);
        check("t6_after_vld", 32'(evt_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ir_key_ctrl.md
# ir_key_ctrl

Controller between the `ir_decoder` instance and the rest of the design. It owns the decoder's `enable` and checks each raw 32-bit NEC frame for integrity and address match. Accepted frames become key events, tagged as new or auto-repeat, and are buffered in a small FIFO for a consumer using a valid/ready handshake. After each frame it closes a guard window on the decoder and tracks key-hold state for the LED and UI logic.

## Interface
- `ADDR`, 8'h00: NEC device address accepted when `ADDR_CHECK`=1.
- `ADDR_CHECK`, 1: 1 = drop frames whose address byte differs from `ADDR`; 0 = accept any address.
- `GUARD_CYC`, 25_000: cycles the decoder is held disabled after each frame (1 ms at 25 MHz); must be ≥1.
- `HOLD_CYC`, 3_000_000: key-hold window in cycles (120 ms); must be ≥2.
- `FIFO_DEPTH`, 4: event FIFO entries, power of two.
- `clk25`  in  1  system clock, 25 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `dec_enable`  out  1  drives `ir_decoder.enable`.
- `dec_ready`  in  1  frame-complete strobe from decoder.
- `dec_command`  in  32  raw frame: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
- `evt_valid`  out  1  FIFO head valid.
- `evt_code`  out  8  FIFO head command byte.
- `evt_repeat`  out  1  FIFO head is an auto-repeat.
- `evt_ready`  in  1  consumer pops head when `evt_valid`&`evt_ready`.
- `key_held`  out  1  hold window running.
- `held_code`  out  8  last accepted command byte.
- `err_cnt`  out  8  integrity-failure count, saturating at 255.
- `drop_cnt`  out  8  FIFO-overflow drop count, saturating at 255.

## Operation
- States: IDLE, CHECK, GUARD.
  - IDLE: `dec_enable`=1. `dec_ready`=1 latches `dec_command` and moves to CHECK.
  - CHECK: one cycle, `dec_enable`=0.
    - Integrity: cmd ^ ~cmd == 8'hFF and addr ^ ~addr == 8'hFF. On failure, `err_cnt`++ and no event.
    - Address: pass on integrity with mismatch (`ADDR_CHECK`=1) is ignored silently; no counter changes.
    - Accept: repeat = `key_held` & (cmd == `held_code`). Push {repeat, cmd} to the FIFO. Load `held_code` = cmd and the hold timer = `HOLD_CYC`.
    - Always go to GUARD and load the guard counter = `GUARD_CYC`-1.
  - GUARD: `dec_enable`=0. Decrement the counter; at 0 go to IDLE.
- `dec_ready` outside IDLE is ignored.
- Hold timer: decrements each cycle while nonzero. `key_held` = (timer != 0).
- FIFO push when full and no pop in the same cycle: event discarded, `drop_cnt`++.
- Push and pop in the same cycle when full: both take effect, no drop.
- Push into an empty FIFO: visible at the head the next cycle.
- Counters saturate and never wrap.
- Reset values: state IDLE, `dec_enable`=1, FIFO empty, `evt_valid`=0, `evt_code`=0, `evt_repeat`=0, `key_held`=0, `held_code`=0, `err_cnt`=0, `drop_cnt`=0, all timers 0.
- Reset mid-GUARD or mid-hold aborts immediately and discards FIFO contents.

## Timing
- `dec_ready` high in cycle N (IDLE): CHECK in N+1; `dec_enable` low from N+1.
- Accepted event: FIFO write at the end of N+1; `evt_valid`=1 in N+2 (empty FIFO).
- `key_held`=1 and `held_code` updated in N+2.
- Guard: `dec_enable` low for cycles N+1 … N+1+`GUARD_CYC`; high again at N+2+`GUARD_CYC`.
- Hold: `key_held` stays high for `HOLD_CYC` cycles after the last accepted frame unless refreshed.
- FIFO outputs are registered (no fall-through). Pop takes effect on the clock edge; the next entry appears the following cycle.
- `evt_valid` does not depend combinationally on `evt_ready`.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `ir_ctrl_pkg`:
  - state enum `ir_ctrl_state_t` {IDLE, CHECK, GUARD}
  - packed struct `ir_evt_t` {repeat, code[7:0]}
  - NEC byte-offset localparams
  - saturating-increment function
- Sub-module `ir_evt_fifo`: synchronous FIFO of `ir_evt_t`, parameter DEPTH, ports push/pop/full/empty/head. The controller FSM, timers and counters live in `ir_key_ctrl`.

## Test plan
Bench parameters: `GUARD_CYC`=8, `HOLD_CYC`=100, `ADDR`=8'h00, `FIFO_DEPTH`=4.
- Valid frame 32'hE31C_FF00 -> one event, code 8'h1C, repeat 0; `evt_valid` 2 cycles after `dec_ready`; `dec_enable` low exactly 9 cycles; `key_held`=1, `held_code`=8'h1C.
- Corrupt frame 32'hE31D_FF00 -> no event, `err_cnt`=1, `key_held` unchanged; address mismatch 32'hE31C_FE01 -> no event, `err_cnt` unchanged.
- 32'hE31C_FF00 twice, 40 cycles apart -> events {0,1C} then {1,1C}; the same pair 150 cycles apart -> both repeat 0; `key_held` falls 100 cycles after the last frame.
- Six valid frames with `evt_ready`=0 -> 4 queued in order, `drop_cnt`=2. Then `evt_ready`=1 -> 4 pops on consecutive cycles, then `evt_valid`=0.
- `dec_ready` pulsed during GUARD -> ignored, no event.
- `rst` asserted mid-GUARD with 2 events queued -> outputs at reset values asynchronously; after release `dec_enable`=1 and the FIFO is empty.
